// File: rtl/alarm_pkg.sv
// Shared constants for the alarm/flow-light stage: FSM state encoding and
// speed codes, used by alarm_ctrl and the downstream alarm comparator.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_SET_ALARM = 2'b01,
        ST_SET_SPEED = 2'b10
    } state_e;

    localparam logic [2:0] SPD_0 = 3'b000;
    localparam logic [2:0] SPD_1 = 3'b001;
    localparam logic [2:0] SPD_2 = 3'b011;
    localparam logic [2:0] SPD_3 = 3'b111;

    // Speed step order 000 -> 001 -> 011 -> 111 -> 000; illegal codes restart at 000.
    function automatic logic [2:0] next_speed(input logic [2:0] spd);
        case (spd)
            SPD_0:   return SPD_1;
            SPD_1:   return SPD_2;
            SPD_2:   return SPD_3;
            SPD_3:   return SPD_0;
            default: return SPD_0;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: 2-flop synchronizer, consecutive-cycle debounce
// counter and a single-cycle pulse on the accepted 0->1 edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic I_CLK,
    input  logic Rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count cycles where the synchronized input disagrees with the accepted level; any agreement restarts the count.
    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = {CW{1'b0}};
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
                cnt_d   = {CW{1'b0}};
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Synchronizer, debounce and pulse registers; reset clears any debounce in progress.
    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/alarm_ctrl.sv
// User-input front end for the alarm/flow-light stage: debounced buttons,
// RUN/SET_ALARM/SET_SPEED mode FSM, registered speed/position/target buses.
// Optional feature macro: ALARM_SNOOZE_EN (snooze button forces speed 000
// for SNOOZE_TICKS position ticks).
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned TICK_CYC     = 50000000,
    parameter int unsigned SNOOZE_TICKS = 4
) (
    input  logic       I_CLK,
    input  logic       Rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_snooze,
    output logic [2:0] flowspeed,
    output logic [1:0] count_light,
    output logic [1:0] count_light1,
    output logic [1:0] mode
);

    localparam int unsigned TW = $clog2(TICK_CYC + 1);
    localparam int unsigned SW = $clog2(SNOOZE_TICKS + 1);

    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    pos_q, pos_d;
    logic [1:0]    alarm_q, alarm_d;
    logic [2:0]    speed_q, speed_d;
    logic [2:0]    flow_q, flow_d;
    logic          mode_press_s;
    logic          up_press_s;
    logic          tick_end_s;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
        .I_CLK   (I_CLK),
        .Rst     (Rst),
        .btn_i   (btn_mode),
        .press_o (mode_press_s)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .I_CLK   (I_CLK),
        .Rst     (Rst),
        .btn_i   (btn_up),
        .press_o (up_press_s)
    );

    assign tick_end_s = (tick_q == TW'(TICK_CYC - 1));

    // Mode FSM plus position/target/speed updates; a mode press wins over a same-cycle up press.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        pos_d   = pos_q;
        alarm_d = alarm_q;
        speed_d = speed_q;
        if (mode_press_s) begin
            case (state_q)
                ST_RUN:       state_d = ST_SET_ALARM;
                ST_SET_ALARM: state_d = ST_SET_SPEED;
                ST_SET_SPEED: state_d = ST_RUN;
                default:      state_d = ST_RUN;
            endcase
            tick_d = {TW{1'b0}};
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (tick_end_s) begin
                        tick_d = {TW{1'b0}};
                        pos_d  = pos_q + 2'd1;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_SET_ALARM: begin
                    tick_d = {TW{1'b0}};
                    if (up_press_s) begin
                        alarm_d = alarm_q + 2'd1;
                    end else begin
                        alarm_d = alarm_q;
                    end
                end
                ST_SET_SPEED: begin
                    tick_d = {TW{1'b0}};
                    if (up_press_s) begin
                        speed_d = next_speed(speed_q);
                    end else begin
                        speed_d = speed_q;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    tick_d  = {TW{1'b0}};
                end
            endcase
        end
    end

`ifdef ALARM_SNOOZE_EN
    logic [SW-1:0] snz_q, snz_d;
    logic          snooze_press_s;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_snooze (
        .I_CLK   (I_CLK),
        .Rst     (Rst),
        .btn_i   (btn_snooze),
        .press_o (snooze_press_s)
    );

    // Snooze countdown in position ticks; armed only in RUN at the alarm position with a non-zero speed.
    always_comb begin
        snz_d = snz_q;
        if (mode_press_s) begin
            snz_d = {SW{1'b0}};
        end else if ((state_q == ST_RUN) && snooze_press_s &&
                     (pos_q == alarm_q) && (speed_q != SPD_0)) begin
            snz_d = SW'(SNOOZE_TICKS);
        end else if ((state_q == ST_RUN) && tick_end_s && (snz_q != {SW{1'b0}})) begin
            snz_d = snz_q - SW'(1);
        end else begin
            snz_d = snz_q;
        end
    end

    // Output speed is silenced while the snooze countdown is running.
    always_comb begin
        flow_d = (snz_d != {SW{1'b0}}) ? SPD_0 : speed_d;
    end

    // Snooze countdown register.
    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst) begin
            snz_q <= {SW{1'b0}};
        end else begin
            snz_q <= snz_d;
        end
    end
`else
    logic [SW-1:0] unused_snooze_s;
    assign unused_snooze_s = {SW{btn_snooze}};

    // Without snooze the output speed is always the stored speed.
    always_comb begin
        flow_d = speed_d;
    end
`endif

    // Controller state and registered output buses.
    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_RUN;
            tick_q  <= {TW{1'b0}};
            pos_q   <= 2'd0;
            alarm_q <= 2'd0;
            speed_q <= SPD_0;
            flow_q  <= SPD_0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            pos_q   <= pos_d;
            alarm_q <= alarm_d;
            speed_q <= speed_d;
            flow_q  <= flow_d;
        end
    end

    assign flowspeed    = flow_q;
    assign count_light  = pos_q;
    assign count_light1 = alarm_q;
    assign mode         = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: a cycle-level reference model pushes
// the expected output tuple each clock; a monitor pops and compares at the
// falling edge. Directed scenarios plus randomized button activity.
module tb_alarm_ctrl;

    localparam int DB = 4;
    localparam int TK = 10;
    localparam int SN = 2;
    localparam int HL = DB + 2;

    logic       I_CLK = 1'b0;
    logic       Rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_snooze = 1'b0;
    logic [2:0] flowspeed;
    logic [1:0] count_light;
    logic [1:0] count_light1;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail = 0;

    // reference model state (abstract: indices and integers)
    int m_mode = 0;
    int m_pos = 0;
    int m_alarm = 0;
    int m_si = 0;
    int m_c = 0;
    int m_snz = 0;
    bit pm_mode = 1'b0;
    bit pm_up = 1'b0;
    bit pm_snz = 1'b0;
    bit lvl [3];
    bit hist [3][HL];
    logic [8:0] exp_q [$];

    alarm_ctrl #(.DEBOUNCE_CYC(DB), .TICK_CYC(TK), .SNOOZE_TICKS(SN)) dut (
        .I_CLK        (I_CLK),
        .Rst          (Rst),
        .btn_mode     (btn_mode),
        .btn_up       (btn_up),
        .btn_snooze   (btn_snooze),
        .flowspeed    (flowspeed),
        .count_light  (count_light),
        .count_light1 (count_light1),
        .mode         (mode)
    );

    initial forever #5 I_CLK = ~I_CLK;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic [8:0] model_out();
        int code;
        code = (1 << m_si) - 1;
        if (m_snz > 0) code = 0;
        return {3'(code), 2'(m_pos), 2'(m_alarm), 2'(m_mode)};
    endfunction

    task automatic model_step();
        bit raw [3];
        bit np [3];
        bit flip;
        bit tick;
        bit snz_ok;
        raw[0] = btn_mode;
        raw[1] = btn_up;
        raw[2] = btn_snooze;
        if (Rst) begin
            m_mode = 0; m_pos = 0; m_alarm = 0; m_si = 0; m_c = 0; m_snz = 0;
            pm_mode = 1'b0; pm_up = 1'b0; pm_snz = 1'b0;
            for (int b = 0; b < 3; b++) begin
                lvl[b] = 1'b0;
                for (int i = 0; i < HL; i++) hist[b][i] = 1'b0;
            end
        end else begin
            if (pm_mode) begin
                m_mode = (m_mode + 1) % 3;
                m_c = 0;
                m_snz = 0;
            end else if (m_mode == 0) begin
                tick = (m_c == TK - 1);
                snz_ok = 1'b0;
`ifdef ALARM_SNOOZE_EN
                snz_ok = pm_snz && (m_pos == m_alarm) && (m_si != 0);
`endif
                if (tick) begin
                    m_c = 0;
                    m_pos = (m_pos + 1) % 4;
                end else begin
                    m_c++;
                end
                if (snz_ok) m_snz = SN;
                else if (tick && m_snz > 0) m_snz--;
            end else if (m_mode == 1) begin
                if (pm_up) m_alarm = (m_alarm + 1) % 4;
            end else begin
                if (pm_up) m_si = (m_si + 1) % 4;
            end
            // a level is accepted once the last DB synchronized samples all oppose it
            for (int b = 0; b < 3; b++) begin
                for (int i = HL - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
                hist[b][0] = raw[b];
                flip = 1'b1;
                for (int i = 2; i < HL; i++) if (hist[b][i] == lvl[b]) flip = 1'b0;
                np[b] = 1'b0;
                if (flip) begin
                    lvl[b] = ~lvl[b];
                    np[b] = lvl[b];
                end
            end
            pm_mode = np[0];
            pm_up = np[1];
            pm_snz = np[2];
        end
        exp_q.push_back(model_out());
    endtask

    // model advances on every rising edge
    initial forever begin
        @(posedge I_CLK);
        model_step();
    end

    // monitor compares DUT outputs to the queued expectation at each falling edge
    initial begin
        logic [8:0] e;
        logic [8:0] g;
        forever begin
            @(negedge I_CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {flowspeed, count_light, count_light1, mode};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    if (n_fail < 40)
                        $display("FAIL scoreboard t=%0t: got flow=%b pos=%0d alarm=%0d mode=%b expected flow=%b pos=%0d alarm=%0d mode=%b",
                                 $time, g[8:6], g[5:4], g[3:2], g[1:0], e[8:6], e[5:4], e[3:2], e[1:0]);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge I_CLK);
            #1;
        end
    endtask

    task automatic press(input bit pm, input bit pu, input bit ps);
        btn_mode = pm; btn_up = pu; btn_snooze = ps;
        cyc(7);
        btn_mode = 1'b0; btn_up = 1'b0; btn_snooze = 1'b0;
        cyc(8);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_flowspeed"}, int'(flowspeed), 0);
        chk({tag, "_count_light"}, int'(count_light), 0);
        chk({tag, "_count_light1"}, int'(count_light1), 0);
        chk({tag, "_mode"}, int'(mode), 0);
    endtask

    task automatic async_reset(input string tag);
        @(negedge I_CLK);
        #2;
        Rst = 1'b1;
        #1;
        check_zero(tag);
        @(posedge I_CLK);
        #1;
        Rst = 1'b0;
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic wait_align();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (m_mode == 0 && m_c == 0 && m_pos == m_alarm) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL align_timeout: got no aligned tick expected one within 200 cycles");
        end
    endtask
`endif

    initial begin
        int pos_frozen;
        int sel;
        // reset
        repeat (3) @(posedge I_CLK);
        #1;
        check_zero("reset");
        Rst = 1'b0;

        // free-running RUN
        cyc(35);
        chk("run35_pos", int'(count_light), 3);
        cyc(10);
        chk("run45_pos_wrap", int'(count_light), 0);
        chk("run45_speed", int'(flowspeed), 0);

        // bouncing mode button, then a stable hold
        for (int i = 0; i < 10; i++) begin
            btn_mode = (i % 2 == 0);
            cyc(2);
        end
        chk("bounce_no_change", int'(mode), 0);
        btn_mode = 1'b1;
        repeat (6) @(posedge I_CLK);
        @(negedge I_CLK);
        chk("hold6_still_run", int'(mode), 0);
        @(posedge I_CLK);
        @(negedge I_CLK);
        chk("hold7_set_alarm", int'(mode), 1);
        @(posedge I_CLK);
        #1;
        btn_mode = 1'b0;
        cyc(8);
        pos_frozen = int'(count_light);

        // five up presses in SET_ALARM
        for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 1'b0);
        chk("alarm_wrap", int'(count_light1), 1);
        chk("pos_frozen", int'(count_light), pos_frozen);

        // SET_SPEED stepping
        press(1'b1, 1'b0, 1'b0);
        chk("enter_set_speed", int'(mode), 2);
        press(1'b0, 1'b1, 1'b0);
        chk("speed_1", int'(flowspeed), 1);
        press(1'b0, 1'b1, 1'b0);
        chk("speed_2", int'(flowspeed), 3);
        press(1'b0, 1'b1, 1'b0);
        chk("speed_3", int'(flowspeed), 7);
        press(1'b0, 1'b1, 1'b0);
        chk("speed_wrap", int'(flowspeed), 0);

        // back round to SET_ALARM, then simultaneous mode+up
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("back_set_alarm", int'(mode), 1);
        press(1'b1, 1'b1, 1'b0);
        chk("simul_mode_wins", int'(mode), 2);
        chk("simul_alarm_kept", int'(count_light1), 1);

`ifdef ALARM_SNOOZE_EN
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("snz_speed_set", int'(flowspeed), 3);
        press(1'b1, 1'b0, 1'b0);
        wait_align();
        press(1'b0, 1'b0, 1'b1);
        chk("snooze_active", int'(flowspeed), 0);
        cyc(10);
        chk("snooze_restored", int'(flowspeed), 3);
        wait_align();
        btn_snooze = 1'b1;
        cyc(7);
        btn_snooze = 1'b0;
        cyc(1);
        chk("snooze_active2", int'(flowspeed), 0);
        async_reset("rst_mid_snooze");
        cyc(10);
`endif

        // reset while a debounce is in progress
        btn_mode = 1'b1;
        cyc(4);
        async_reset("rst_mid_debounce");
        cyc(10);
        btn_mode = 1'b0;
        cyc(10);

        // randomized button activity
        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 3));
            btn_mode = (sel == 0 || sel == 3);
            btn_up = (sel == 1 || sel == 3);
            btn_snooze = (sel == 2);
            cyc(int'($urandom_range(1, 9)));
            btn_mode = 1'b0;
            btn_up = 1'b0;
            btn_snooze = 1'b0;
            cyc(int'($urandom_range(1, 9)));
        end
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
